// File: rtl/uart_pkg.sv
// Shared UART constants for the receiver and transmitter at 20 MHz / 256000 baud.
// Also holds the receiver state encoding.
package uart_pkg;

  // 20 MHz / 256000 baud = 78.125, so one bit lasts 79 SYS_CLK cycles (counter 0..78).
  localparam logic [15:0] BAUD_CNT_END = 16'd78;
  localparam logic [15:0] SAMPLE_POINT = BAUD_CNT_END / 16'd2;

  localparam int unsigned DATA_BITS = 8;

  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for the asynchronous Rxd pin, plus a third flop for falling-edge detection.
// All flops preset to 1 so that reset looks like an idle line and no false edge is seen.
module uart_rx_sync (
  input  logic SYS_CLK,
  input  logic RST_N,
  input  logic Rxd,
  output logic rxd_s,
  output logic rxd_fall
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
      prev_q <= 1'b1;
    end else begin
      meta_q <= Rxd;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign rxd_s    = sync_q;
  assign rxd_fall = prev_q & ~sync_q;

endmodule

// File: rtl/uart_rx_byte.sv
// 8N1 UART receiver: samples each bit at mid-period and delivers bytes with a one-cycle done strobe.
// The frame ends at mid-stop-bit so a start bit directly after the stop bit is still caught.
module uart_rx_byte
  import uart_pkg::*;
(
  input  logic       SYS_CLK,
  input  logic       RST_N,
  input  logic       Rxd,
  output logic [7:0] data_out,
  output logic       rx_done,
  output logic       frame_err,
  output logic       rx_busy
);

  logic        rxd_s;
  logic        rxd_fall;

  logic [1:0]  state_q, state_d;
  logic [15:0] baud_q, baud_d;
  logic [3:0]  bit_q, bit_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        done_q, done_d;
  logic        ferr_q, ferr_d;

  logic        baud_wrap;
  logic        sample_now;
  logic [15:0] baud_inc;

  uart_rx_sync u_sync (
    .SYS_CLK  (SYS_CLK),
    .RST_N    (RST_N),
    .Rxd      (Rxd),
    .rxd_s    (rxd_s),
    .rxd_fall (rxd_fall)
  );

  assign baud_wrap  = (baud_q == BAUD_CNT_END);
  assign sample_now = (baud_q == SAMPLE_POINT);
  assign baud_inc   = baud_wrap ? 16'd0 : baud_q + 16'd1;

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      RX_IDLE: begin
        baud_d = 16'd0;
        bit_d  = 4'd0;
        if (rxd_fall) begin
          state_d = RX_START;
        end
      end

      RX_START: begin
        baud_d = baud_inc;
        // A start bit that is high again at mid-bit was only a glitch.
        if (sample_now && rxd_s) begin
          state_d = RX_IDLE;
          baud_d  = 16'd0;
        end else if (baud_wrap) begin
          state_d = RX_DATA;
          bit_d   = 4'd0;
        end
      end

      RX_DATA: begin
        baud_d = baud_inc;
        if (sample_now) begin
          shift_d = {rxd_s, shift_q[7:1]};
        end
        if (baud_wrap) begin
          if (bit_q == 4'(DATA_BITS - 1)) begin
            state_d = RX_STOP;
            bit_d   = 4'd0;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end

      RX_STOP: begin
        baud_d = baud_inc;
        if (sample_now) begin
          if (rxd_s) begin
            data_d = shift_q;
            done_d = 1'b1;
          end else begin
            ferr_d = 1'b1;
          end
          state_d = RX_IDLE;
          baud_d  = 16'd0;
        end
      end

      default: begin
        state_d = RX_IDLE;
        baud_d  = 16'd0;
        bit_d   = 4'd0;
      end
    endcase
  end

  always_ff @(posedge SYS_CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= RX_IDLE;
      baud_q  <= 16'd0;
      bit_q   <= 4'd0;
      shift_q <= 8'd0;
      data_q  <= 8'd0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
    end
  end

  assign data_out  = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign rx_busy   = (state_q != RX_IDLE);

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: serial frames are generated by a bit-level transmitter model,
// expected bytes/errors go into a scoreboard and are compared whenever the receiver strobes.
module tb_uart_rx_byte;

  localparam int BIT_CYCLES = 79;

  typedef struct {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic       SYS_CLK;
  logic       RST_N;
  logic       Rxd;
  logic [7:0] data_out;
  logic       rx_done;
  logic       frame_err;
  logic       rx_busy;

  exp_t       sb[$];
  int         doneCycles[$];
  int         checkCount;
  int         passCount;
  int         cycle;
  int         ferrCount;
  logic       prevStrobe;
  logic [7:0] lastGood;

  uart_rx_byte dut (
    .SYS_CLK   (SYS_CLK),
    .RST_N     (RST_N),
    .Rxd       (Rxd),
    .data_out  (data_out),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .rx_busy   (rx_busy)
  );

  initial SYS_CLK = 1'b0;
  always #25 SYS_CLK = ~SYS_CLK;

  initial cycle = 0;
  always @(posedge SYS_CLK) cycle = cycle + 1;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount = checkCount + 1;
    if (observed === expected) begin
      passCount = passCount + 1;
    end else begin
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", tag, observed, expected, cycle);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge SYS_CLK);
  endtask

  task automatic sendBit(input logic b);
    Rxd = b;
    waitCycles(BIT_CYCLES);
  endtask

  // Transmitter model: start bit, 8 data bits LSB first, stop bit; expectation pushed up front.
  task automatic applyStimulus(input logic [7:0] value, input logic stopBit);
    exp_t e;
    e.err  = ~stopBit;
    e.data = stopBit ? value : lastGood;
    if (stopBit) lastGood = value;
    sb.push_back(e);
    sendBit(1'b0);
    for (int i = 0; i < 8; i++) sendBit(value[i]);
    sendBit(stopBit);
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge SYS_CLK);
      n = n + 1;
    end
    checkOutput("sb_drain", sb.size(), 0);
  endtask

  // Scoreboard monitor: every strobe must match the oldest pending expectation.
  always @(negedge SYS_CLK) begin
    if (RST_N && (rx_done || frame_err)) begin
      checkOutput("strobe_excl", {31'd0, rx_done & frame_err}, 0);
      checkOutput("strobe_width", {31'd0, prevStrobe}, 0);
      checkOutput("strobe_expected", (sb.size() > 0) ? 1 : 0, 1);
      if (frame_err) ferrCount = ferrCount + 1;
      if (rx_done) doneCycles.push_back(cycle);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        checkOutput("strobe_kind", {31'd0, frame_err}, {31'd0, e.err});
        checkOutput("strobe_data", {24'd0, data_out}, {24'd0, e.data});
      end
    end
    prevStrobe = rx_done | frame_err;
  end

  initial begin
    #(60000 * 50);
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    checkCount = 0;
    passCount  = 0;
    ferrCount  = 0;
    prevStrobe = 1'b0;
    lastGood   = 8'h00;
    RST_N      = 1'b0;
    Rxd        = 1'b1;
    waitCycles(5);
    checkOutput("rst_data", {24'd0, data_out}, 0);
    checkOutput("rst_done", {31'd0, rx_done}, 0);
    checkOutput("rst_ferr", {31'd0, frame_err}, 0);
    checkOutput("rst_busy", {31'd0, rx_busy}, 0);
    RST_N = 1'b1;
    waitCycles(20);

    $display("[TB] single byte 0x55");
    applyStimulus(8'h55, 1'b1);
    waitDrain(200);
    checkOutput("b55_data", {24'd0, data_out}, 32'h55);
    checkOutput("b55_busy", {31'd0, rx_busy}, 0);
    checkOutput("b55_noferr", ferrCount, 0);
    waitCycles(30);

    $display("[TB] back-to-back 0xA5, 0x3C");
    doneCycles.delete();
    applyStimulus(8'hA5, 1'b1);
    applyStimulus(8'h3C, 1'b1);
    waitDrain(200);
    checkOutput("b2b_count", doneCycles.size(), 2);
    if (doneCycles.size() == 2)
      checkOutput("b2b_gap", doneCycles[1] - doneCycles[0], 790);
    waitCycles(30);

    $display("[TB] start glitch");
    Rxd = 1'b0;
    waitCycles(20);
    checkOutput("glitch_busy_mid", {31'd0, rx_busy}, 1);
    Rxd = 1'b1;
    waitCycles(25);
    checkOutput("glitch_busy_end", {31'd0, rx_busy}, 0);
    waitCycles(100);
    checkOutput("glitch_data", {24'd0, data_out}, 32'h3C);

    $display("[TB] framing error on 0x0F");
    ferrCount = 0;
    applyStimulus(8'h0F, 1'b0);
    Rxd = 1'b1;
    waitDrain(200);
    waitCycles(100);
    checkOutput("ferr_count", ferrCount, 1);
    checkOutput("ferr_hold", {24'd0, data_out}, 32'h3C);

    $display("[TB] reset during bit 4 of 0xFF, then 0x81");
    sendBit(1'b0);
    for (int i = 0; i < 4; i++) sendBit(1'b1);
    Rxd = 1'b1;
    waitCycles(30);
    RST_N = 1'b0;
    waitCycles(3);
    checkOutput("mid_rst_data", {24'd0, data_out}, 0);
    checkOutput("mid_rst_busy", {31'd0, rx_busy}, 0);
    checkOutput("mid_rst_done", {31'd0, rx_done}, 0);
    RST_N = 1'b1;
    lastGood = 8'h00;
    waitCycles(BIT_CYCLES * 5);
    checkOutput("post_rst_busy", {31'd0, rx_busy}, 0);
    checkOutput("post_rst_data", {24'd0, data_out}, 0);
    applyStimulus(8'h81, 1'b1);
    waitDrain(200);
    checkOutput("b81_data", {24'd0, data_out}, 32'h81);
    waitCycles(30);

    $display("[TB] loopback 0x00, 0xFF, 0x5A");
    doneCycles.delete();
    applyStimulus(8'h00, 1'b1);
    sendBit(1'b1);
    applyStimulus(8'hFF, 1'b1);
    sendBit(1'b1);
    applyStimulus(8'h5A, 1'b1);
    waitDrain(200);
    checkOutput("loop_count", doneCycles.size(), 3);
    checkOutput("loop_last", {24'd0, data_out}, 32'h5A);
    waitCycles(100);

    checkOutput("sb_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule
